// File: rtl/controle_multiciclo.sv
// Multicycle control FSM: fetch / decode / execute / write-back / branch-jump sequencing for the 4-bit-opcode datapath.
// Optional macro CONTADOR_INSTR_EN adds the retired-instruction counter output instr_cont.
module controle_multiciclo #(
    parameter int LARGURA_CONT = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              opcode,
    input  logic                    mem_pronto,
    output logic                    LerMem,
    output logic                    EscIR,
    output logic                    EscCP,
    output logic                    EscCondCP,
    output logic [3:0]              ULA_OP,
    output logic                    ULA_A,
    output logic [1:0]              ULA_B,
    output logic [1:0]              FonteCP,
    output logic                    EscReg,
    output logic [2:0]              estado,
    output logic                    ilegal
`ifdef CONTADOR_INSTR_EN
    ,
    output logic [LARGURA_CONT-1:0] instr_cont
`endif
);

    localparam logic [2:0] BUSCA   = 3'd0;
    localparam logic [2:0] DECOD   = 3'd1;
    localparam logic [2:0] EXEC    = 3'd2;
    localparam logic [2:0] ESCRITA = 3'd3;
    localparam logic [2:0] DESVIO  = 3'd4;
    localparam logic [2:0] ERRO    = 3'd5;

    localparam logic [3:0] OP_ULTIMO_ULA = 4'd10;
    localparam logic [3:0] OP_JUMP       = 4'd11;
    localparam logic [3:0] OP_BRANCH     = 4'd12;

    localparam logic [1:0] B_REG    = 2'b00;
    localparam logic [1:0] B_UM     = 2'b01;
    localparam logic [1:0] B_IMED   = 2'b10;
    localparam logic [1:0] B_OFFSET = 2'b11;

    localparam logic [1:0] CP_ULA     = 2'b00;
    localparam logic [1:0] CP_ULA_OUT = 2'b01;
    localparam logic [1:0] CP_JUMP    = 2'b10;

    generate
        if (LARGURA_CONT < 1) begin : g_largura_invalida
            $error("LARGURA_CONT must be at least 1");
        end
    endgenerate

    logic [2:0] estado_reg;
    logic [2:0] estado_next;
    logic [3:0] op_reg;
    logic       carrega_ir;

    // Ops 2 and 6..10 take the immediate field as ALU operand B.
    function automatic logic usa_imediato(input logic [3:0] op);
        return (op == 4'd2) || ((op >= 4'd6) && (op <= OP_ULTIMO_ULA));
    endfunction

    assign carrega_ir = (estado_reg == BUSCA) && mem_pronto;

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_reg <= BUSCA;
            op_reg     <= 4'd0;
        end else begin
            estado_reg <= estado_next;
            if (carrega_ir) begin
                op_reg <= opcode;
            end
        end
    end

    always_comb begin
        estado_next = estado_reg;
        case (estado_reg)
            BUSCA: begin
                if (mem_pronto) begin
                    estado_next = DECOD;
                end
            end
            DECOD: begin
                if (op_reg <= OP_ULTIMO_ULA) begin
                    estado_next = EXEC;
                end else if (op_reg <= OP_BRANCH) begin
                    estado_next = DESVIO;
                end else begin
                    estado_next = ERRO;
                end
            end
            EXEC:    estado_next = ESCRITA;
            ESCRITA: estado_next = BUSCA;
            DESVIO:  estado_next = BUSCA;
            ERRO:    estado_next = ERRO;
            default: estado_next = ERRO;
        endcase
    end

    // Outputs decode from the state and latched opcode; reset overrides everything so no write escapes an abort.
    always_comb begin
        LerMem    = 1'b0;
        EscIR     = 1'b0;
        EscCP     = 1'b0;
        EscCondCP = 1'b0;
        ULA_OP    = 4'd0;
        ULA_A     = 1'b0;
        ULA_B     = B_REG;
        FonteCP   = CP_ULA;
        EscReg    = 1'b0;
        ilegal    = 1'b0;
        if (!reset) begin
            case (estado_reg)
                BUSCA: begin
                    LerMem = 1'b1;
                    ULA_B  = B_UM;
                    EscIR  = mem_pronto;
                    EscCP  = mem_pronto;
                end
                DECOD: begin
                    ULA_B = B_OFFSET;
                end
                EXEC, ESCRITA: begin
                    ULA_A  = 1'b1;
                    ULA_OP = op_reg;
                    ULA_B  = usa_imediato(op_reg) ? B_IMED : B_REG;
                    EscReg = (estado_reg == ESCRITA);
                end
                DESVIO: begin
                    if (op_reg == OP_JUMP) begin
                        EscCP   = 1'b1;
                        FonteCP = CP_JUMP;
                    end else if (op_reg == OP_BRANCH) begin
                        ULA_A     = 1'b1;
                        ULA_B     = B_REG;
                        ULA_OP    = OP_BRANCH;
                        EscCondCP = 1'b1;
                        FonteCP   = CP_ULA_OUT;
                    end
                end
                ERRO: begin
                    ilegal = 1'b1;
                end
                default: begin
                    ilegal = 1'b0;
                end
            endcase
        end
    end

    assign estado = estado_reg;

`ifdef CONTADOR_INSTR_EN
    logic [LARGURA_CONT-1:0] cont_reg;
    logic                    retira;

    // ESCRITA and DESVIO always hand back to BUSCA, so leaving them is a retirement.
    assign retira = (estado_reg == ESCRITA) || (estado_reg == DESVIO);

    always_ff @(posedge clk) begin
        if (reset) begin
            cont_reg <= '0;
        end else if (retira) begin
            cont_reg <= cont_reg + 1'b1;
        end
    end

    assign instr_cont = cont_reg;
`endif

endmodule

// File: tb/tb_controle_multiciclo.sv
// Scoreboard bench for controle_multiciclo: per-cycle stimulus and expected output vectors are queued, then replayed and compared.
module tb_controle_multiciclo;

`ifdef CONTADOR_INSTR_EN
    localparam int LARG = 4;
`else
    localparam int LARG = 16;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] opcode = 4'd0;
    logic       mem_pronto = 1'b0;
    logic       LerMem, EscIR, EscCP, EscCondCP, ULA_A, EscReg, ilegal;
    logic [3:0] ULA_OP;
    logic [1:0] ULA_B, FonteCP;
    logic [2:0] estado;
`ifdef CONTADOR_INSTR_EN
    logic [LARG-1:0] instr_cont;
`endif

    always #5 clk = ~clk;

    controle_multiciclo #(.LARGURA_CONT(LARG)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .mem_pronto (mem_pronto),
        .LerMem     (LerMem),
        .EscIR      (EscIR),
        .EscCP      (EscCP),
        .EscCondCP  (EscCondCP),
        .ULA_OP     (ULA_OP),
        .ULA_A      (ULA_A),
        .ULA_B      (ULA_B),
        .FonteCP    (FonteCP),
        .EscReg     (EscReg),
        .estado     (estado),
        .ilegal     (ilegal)
`ifdef CONTADOR_INSTR_EN
        ,
        .instr_cont (instr_cont)
`endif
    );

    typedef struct packed {
        logic       rst;
        logic       mp;
        logic [3:0] opc;
    } stim_t;

    stim_t       stim_q[$];
    logic [17:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_cont = 0;

    logic [17:0] obs;
    assign obs = {estado, LerMem, EscIR, EscCP, EscCondCP, ULA_OP, ULA_A, ULA_B, FonteCP, EscReg, ilegal};

    // Vector layout: estado, LerMem, EscIR, EscCP, EscCondCP, ULA_OP, ULA_A, ULA_B, FonteCP, EscReg, ilegal
    function automatic logic [17:0] mk(input logic [2:0] st, input logic ler, input logic ir,
                                       input logic cp, input logic cond, input logic [3:0] op,
                                       input logic a, input logic [1:0] b, input logic [1:0] f,
                                       input logic wr, input logic il);
        return {st, ler, ir, cp, cond, op, a, b, f, wr, il};
    endfunction

    function automatic logic [17:0] v_idle();
        return mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0);
    endfunction

    function automatic logic [17:0] v_quiet(input logic [2:0] st);
        return mk(st, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    endfunction

    function automatic logic [17:0] v_erro();
        return mk(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
    endfunction

    task automatic push(input logic rst, input logic mp, input logic [3:0] opc, input logic [17:0] e);
        stim_q.push_back({rst, mp, opc});
        exp_q.push_back(e);
        if (rst) exp_cont = 0;
    endtask

    task automatic push_garbage(input logic [17:0] e);
        push(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), e);
    endtask

    // One instruction: optional idle fetch cycles, then the expected state-by-state outputs.
    task automatic push_instr(input logic [3:0] op, input int waits);
        logic [1:0] b;
        $display("instr op=%0d wait=%0d", op, waits);
        for (int i = 0; i < waits; i++) push(1'b0, 1'b0, 4'($urandom_range(0, 15)), v_idle());
        push(1'b0, 1'b1, op, mk(3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0));
        push_garbage(mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0));
        if (op <= 4'd10) begin
            b = (op == 4'd0 || op == 4'd1 || op == 4'd3 || op == 4'd4 || op == 4'd5) ? 2'b00 : 2'b10;
            push_garbage(mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, op, 1'b1, b, 2'b00, 1'b0, 1'b0));
            push_garbage(mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, op, 1'b1, b, 2'b00, 1'b1, 1'b0));
            exp_cont++;
        end else if (op == 4'd11) begin
            push_garbage(mk(3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0));
            exp_cont++;
        end else if (op == 4'd12) begin
            push_garbage(mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 4'd12, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0));
            exp_cont++;
        end else begin
            push_garbage(v_erro());
        end
    endtask

    task automatic run_queue();
        stim_t       s;
        logic [17:0] e;
        while (stim_q.size() > 0) begin
            @(negedge clk);
            s = stim_q.pop_front();
            reset = s.rst;
            mem_pronto = s.mp;
            opcode = s.opc;
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL outputs t=%0t estado=%0d got=%b expected=%b", $time, estado, obs, e);
            end
        end
    endtask

    task automatic test_reset();
        push(1'b1, 1'b0, 4'd0, v_quiet(3'd0));
        push(1'b1, 1'b0, 4'd0, v_quiet(3'd0));
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 4'($urandom_range(0, 15)), v_idle());
        run_queue();
    endtask

    task automatic test_alu();
        push_instr(4'd3, 2);
        push_instr(4'd0, 0);
        push_instr(4'd5, 1);
        run_queue();
    endtask

    task automatic test_imm();
        push_instr(4'd6, 1);
        push_instr(4'd2, 0);
        run_queue();
    endtask

    task automatic test_jump();
        push_instr(4'd11, 0);
        run_queue();
    endtask

    task automatic test_branch();
        push_instr(4'd12, 3);
        run_queue();
    endtask

    task automatic test_back_to_back();
        for (int op = 0; op <= 12; op++) push_instr(4'(op), 0);
        push(1'b0, 1'b0, 4'd0, v_idle());
        run_queue();
    endtask

    task automatic test_reset_abort();
        $display("instr op=3 aborted by reset in EXEC");
        push(1'b0, 1'b1, 4'd3, mk(3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0));
        push_garbage(mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0));
        push(1'b1, 1'b1, 4'd3, v_quiet(3'd2));
        push(1'b0, 1'b0, 4'd9, v_idle());
        run_queue();
    endtask

    task automatic test_illegal();
        for (int k = 13; k <= 15; k++) begin
            push_instr(4'(k), 0);
            for (int i = 0; i < ((k == 14) ? 9 : 3); i++) push(1'b0, 1'b1, 4'($urandom_range(0, 15)), v_erro());
            push(1'b1, 1'b1, 4'd0, v_quiet(3'd5));
            push(1'b0, 1'b0, 4'd0, v_idle());
        end
        run_queue();
    endtask

`ifdef CONTADOR_INSTR_EN
    task automatic check_cont(input string name);
        logic [LARG-1:0] ec;
        ec = LARG'(exp_cont);
        checks++;
        if (instr_cont !== ec) begin
            errors++;
            $display("FAIL %s instr_cont got=%0d expected=%0d", name, instr_cont, ec);
        end
    endtask

    task automatic test_contador();
        push(1'b1, 1'b0, 4'd0, v_quiet(3'd0));
        push(1'b0, 1'b0, 4'd0, v_idle());
        run_queue();
        check_cont("cont_reset");
        for (int i = 0; i < 3; i++) push_instr(4'd0, 0);
        push(1'b0, 1'b0, 4'd0, v_idle());
        run_queue();
        check_cont("cont_three");
        push_instr(4'd13, 0);
        for (int i = 0; i < 4; i++) push(1'b0, 1'b1, 4'd0, v_erro());
        run_queue();
        check_cont("cont_erro");
        push(1'b1, 1'b0, 4'd0, v_quiet(3'd5));
        push(1'b0, 1'b0, 4'd0, v_idle());
        for (int i = 0; i < 15; i++) push_instr(4'd11, 0);
        push(1'b0, 1'b0, 4'd0, v_idle());
        run_queue();
        check_cont("cont_full");
        push_instr(4'd12, 0);
        push(1'b0, 1'b0, 4'd0, v_idle());
        run_queue();
        check_cont("cont_wrap");
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_imm();
        test_jump();
        test_branch();
        test_back_to_back();
        test_reset_abort();
        test_illegal();
`ifdef CONTADOR_INSTR_EN
        test_contador();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
